delay_line_fifo: RTL and testbench
==================================

DELAY_LINE_FIFO -- requirements
Module: delay_line_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, data bits per entry; legal values are 1 or more.
REQ-002 The block SHALL have parameter DEPTH, default 4, number of entries; it must be a power of two and 2 or more.
REQ-003 The block SHALL have port CLK, input, width 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RESET, input, width 1, synchronous active-high reset.
REQ-005 The block SHALL have port I, input, width WIDTH, write data from the upstream two-stage delay-line output.
REQ-006 The block SHALL have port I_valid, input, width 1, meaning I carries a word this cycle.
REQ-007 The block SHALL have port I_ready, output, width 1, meaning the block accepts I this cycle.
REQ-008 The block SHALL have port O, output, width WIDTH, head-of-queue data.
REQ-009 The block SHALL have port O_valid, output, width 1, meaning O holds a valid word.
REQ-010 The block SHALL have port O_ready, input, width 1, meaning the consumer takes O this cycle.
REQ-011 The block SHALL have port count, output, width clog2(DEPTH)+1, current occupancy from 0 to DEPTH.

Function
REQ-012 A push SHALL occur on a rising edge with I_valid=1 and I_ready=1; a pop SHALL occur with O_valid=1 and O_ready=1.
REQ-013 I_ready SHALL be (count < DEPTH), registered-state-derived only, with no combinational path from O_ready.
REQ-014 O_valid SHALL be (count > 0); O SHALL equal the oldest stored word while O_valid=1 and all-zero while O_valid=0.
REQ-015 Latency SHALL be one cycle: a word pushed at edge n appears on O with O_valid=1 after edge n; there is no same-cycle bypass when empty.
REQ-016 Push only SHALL increment count; pop only SHALL decrement it; push and pop together SHALL leave count unchanged and preserve order.
REQ-017 When full, I_ready=0, so push is blocked even if a pop happens in the same cycle; I_ready rises the cycle after the pop.
REQ-018 When empty, O_valid=0, so O_ready is ignored and count never underflows.
REQ-019 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap or a duplicated entry.
REQ-020 Data order SHALL be strictly FIFO; no word is dropped, duplicated or reordered across any push/pop pattern.
REQ-021 I_valid with I_ready=0 SHALL have no effect on state.

Reset
REQ-022 With RESET=1 at a rising edge, count, read pointer and write pointer SHALL become 0; afterwards O_valid=0, O=0 and I_ready=1.
REQ-023 Reset SHALL take priority over a simultaneous push or pop, and all stored words SHALL be discarded, including when reset occurs mid-stream.
REQ-024 Storage array contents need not be reset; O is masked by O_valid per REQ-014.

Structure
REQ-025 A shared package SHALL hold the WIDTH and DEPTH defaults and the count/pointer width constants derived from clog2(DEPTH).
REQ-026 Storage SHALL be a separate sub-module, delay_line_fifo_mem: DEPTH by WIDTH, one synchronous write port and one combinational read port; pointer and count control stays in delay_line_fifo.

Verification
REQ-027 Scenario: after reset, push 1,2,3 on consecutive cycles with O_ready=0. Required: count=3 and O=1 with O_valid=1.
REQ-028 Scenario: from empty, push 2 at edge n with O_ready=1. Required: O_valid=0 before edge n, then O=2 and O_valid=1 after edge n; pop at edge n+1 returns count to 0.
REQ-029 Scenario: fill with 0,1,2,3 and hold I_valid=1 with I=1 while pulsing O_ready for one cycle. Required: I_ready=0 during the pop edge, 1 the next cycle; 1 is written only after that; output order is 0,1,2,3,1.
REQ-030 Scenario: stream 12 words with I_valid=1 and O_ready=1 every cycle. Required: count stays at 1 after the first edge, output equals input delayed one cycle, and the pointers wrap three times.
REQ-031 Scenario: with count=3, assert RESET together with I_valid=1 and O_ready=1. Required: next cycle count=0, O_valid=0, O=0, I_ready=1.
REQ-032 Scenario: O_ready=1 while empty for 3 cycles. Required: count remains 0 and O_valid remains 0.

Source files
------------

// File: rtl/delay_line_fifo_pkg.sv
// delay_line_fifo_pkg: default sizing and derived width constants for the delay-line FIFO
package delay_line_fifo_pkg;
  localparam int WIDTH_DEF = 2;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W = $clog2(DEPTH_DEF);
  localparam int CNT_W = PTR_W + 1;
endpackage

// File: rtl/delay_line_fifo_mem.sv
// delay_line_fifo_mem: DEPTH x WIDTH storage, synchronous write, combinational read
module delay_line_fifo_mem #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge CLK)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/delay_line_fifo.sv
// delay_line_fifo: registered-ready FIFO with one-cycle latency and no empty bypass
module delay_line_fifo
  import delay_line_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready,
  output logic [CW-1:0]    count
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [PW-1:0] rp, wp;
  logic [WIDTH-1:0] rdata;
  logic push, pop;
  assign I_ready = count < FULL;
  assign O_valid = count != '0;
  assign O = O_valid ? rdata : '0;
  assign push = I_valid & I_ready;
  assign pop = O_valid & O_ready;
  always_ff @(posedge CLK)
    if (RESET) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  delay_line_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .CLK(CLK),
    .we(push),
    .waddr(wp),
    .wdata(I),
    .raddr(rp),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_delay_line_fifo.sv
// tb_delay_line_fifo: directed scenarios plus random traffic against a queue model
module tb_delay_line_fifo;
  import delay_line_fifo_pkg::*;
  localparam int W = WIDTH_DEF;
  localparam int D = DEPTH_DEF;
  logic CLK, RESET, I_valid, I_ready, O_valid, O_ready;
  logic [W-1:0] I, O;
  logic [CNT_W-1:0] count;
  int q[$];
  int errs = 0, checks = 0;

  delay_line_fifo dut (
    .CLK(CLK), .RESET(RESET), .I(I), .I_valid(I_valid), .I_ready(I_ready),
    .O(O), .O_valid(O_valid), .O_ready(O_ready), .count(count)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic iv, input int d, input logic ordy);
    bit pu, po;
    RESET = rst; I_valid = iv; I = W'(d); O_ready = ordy;
    chk("count", 32'(count), q.size());
    chk("o_valid", 32'(O_valid), 32'(q.size() != 0));
    chk("o", 32'(O), q.size() != 0 ? q[0] : 0);
    chk("i_ready", 32'(I_ready), 32'(q.size() < D));
    @(posedge CLK);
    if (rst) q.delete();
    else begin
      pu = iv && q.size() < D;
      po = ordy && q.size() > 0;
      if (po) void'(q.pop_front());
      if (pu) q.push_back(d % (1 << W));
    end
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1; I_valid = 0; I = '0; O_ready = 0;
    @(posedge CLK); @(negedge CLK);
    step(0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) step(0, 1, k, 0);
    chk("fill3_count", 32'(count), 3);
    chk("fill3_o", 32'(O), 1);
    step(1, 0, 0, 0);
    step(0, 1, 2, 1);
    chk("lat_o", 32'(O), 2);
    chk("lat_valid", 32'(O_valid), 1);
    step(0, 0, 0, 1);
    chk("lat_drain", 32'(count), 0);
    for (int k = 0; k < 4; k++) step(0, 1, k, 0);
    chk("full_ready", 32'(I_ready), 0);
    step(0, 1, 1, 1);
    chk("after_pop_ready", 32'(I_ready), 1);
    chk("after_pop_count", 32'(count), 3);
    step(0, 1, 1, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1);
    for (int k = 0; k < 12; k++) step(0, 1, k, 1);
    chk("stream_count", 32'(count), 1);
    step(0, 1, 3, 0);
    step(0, 1, 2, 0);
    chk("pre_rst_count", 32'(count), 3);
    step(1, 1, 1, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_o", 32'(O), 0);
    chk("rst_ready", 32'(I_ready), 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
    chk("empty_count", 32'(count), 0);
    chk("empty_valid", 32'(O_valid), 0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, int'($urandom_range(0, (1 << W) - 1)), $urandom_range(0, 1) != 0);
    step(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
